// File: rtl/alu_vector_checker.sv
// rtl/alu_vector_checker.sv - drives operand vectors into a 4-bit ALU, samples C after a settle time, scores against a golden model
// Optional sticky first-failure capture enabled by defining ALU_CHECK_STICKY_EN.
module alu_vector_checker #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_ctrl,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [1:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   alu_c,
    input  logic               clear_counts,
    output logic               res_valid,
    output logic [WIDTH-1:0]   res_c,
    output logic [WIDTH-1:0]   res_expected,
    output logic               res_mismatch,
    output logic [CNT_W-1:0]   pass_count,
    output logic [CNT_W-1:0]   fail_count
`ifdef ALU_CHECK_STICKY_EN
    ,
    output logic               fail_seen,
    output logic [3*WIDTH+1:0] fail_vec
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] res_c_q, res_c_d, res_exp_q, res_exp_d;
    logic             res_mis_q, res_mis_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [WIDTH-1:0] golden;
    logic             accept, sample, mismatch;

    always_comb begin
        golden = '0;
        case (alu_ctrl_q)
            2'd0:    golden = alu_a_q + alu_b_q;
            2'd1:    golden = alu_a_q - alu_b_q;
            2'd2:    golden = alu_a_q & alu_b_q;
            default: golden = alu_a_q | alu_b_q;
        endcase
    end

    assign in_ready = (state_q != ST_SETTLE);
    assign accept   = in_valid & in_ready;
    // counter == 1 marks edge T+SETTLE_CYCLES after the accept edge T
    assign sample   = (state_q == ST_SETTLE) && (cnt_q == 8'd1);
    assign mismatch = (alu_c != golden);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        res_c_d    = res_c_q;
        res_exp_d  = res_exp_q;
        res_mis_d  = res_mis_q;
        pass_d     = pass_q;
        fail_d     = fail_q;

        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETTLE;
            ST_SETTLE: if (sample) state_d = ST_REPORT;
                       else        cnt_d   = cnt_q - 8'd1;
            ST_REPORT: state_d = accept ? ST_SETTLE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (accept) begin
            alu_a_d    = in_a;
            alu_b_d    = in_b;
            alu_ctrl_d = in_ctrl;
            cnt_d      = SETTLE_LOAD;
        end

        if (sample) begin
            res_c_d   = alu_c;
            res_exp_d = golden;
            res_mis_d = mismatch;
        end

        // A clear on the sample edge discards that result from the tallies
        if (clear_counts) begin
            pass_d = '0;
            fail_d = '0;
        end else if (sample) begin
            if (mismatch) begin
                if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
            end else begin
                if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            res_c_q    <= '0;
            res_exp_q  <= '0;
            res_mis_q  <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            res_c_q    <= res_c_d;
            res_exp_q  <= res_exp_d;
            res_mis_q  <= res_mis_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

`ifdef ALU_CHECK_STICKY_EN
    logic                 seen_q, seen_d;
    logic [3*WIDTH+1:0]   vec_q, vec_d;

    always_comb begin
        seen_d = seen_q;
        vec_d  = vec_q;
        if (clear_counts) begin
            seen_d = 1'b0;
            vec_d  = '0;
        end else if (sample && mismatch && !seen_q) begin
            seen_d = 1'b1;
            vec_d  = {alu_a_q, alu_b_q, alu_ctrl_q, alu_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
            vec_q  <= '0;
        end else begin
            seen_q <= seen_d;
            vec_q  <= vec_d;
        end
    end

    assign fail_seen = seen_q;
    assign fail_vec  = vec_q;
`endif

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign res_valid    = (state_q == ST_REPORT);
    assign res_c        = res_c_q;
    assign res_expected = res_exp_q;
    assign res_mismatch = res_mis_q;
    assign pass_count   = pass_q;
    assign fail_count   = fail_q;

endmodule

// File: tb/tb_alu_vector_checker.sv
// tb/tb_alu_vector_checker.sv - scoreboard bench for alu_vector_checker with a behavioural ALU and reference model
module tb_alu_vector_checker;
    localparam int S = 4;
    localparam int CMAX = 65535;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0, in_b = '0;
    logic [1:0] in_ctrl = '0;
    logic       clear_counts = 1'b0;
    logic       fault = 1'b0;
    logic       in_ready, res_valid, res_mismatch;
    logic [3:0] alu_a, alu_b, alu_c, res_c, res_expected;
    logic [1:0] alu_ctrl;
    logic [15:0] pass_count, fail_count;
`ifdef ALU_CHECK_STICKY_EN
    logic        fail_seen;
    logic [13:0] fail_vec;
`endif

    // second instance for counter saturation
    logic       v2 = 1'b0;
    logic [3:0] a2 = '0, b2 = '0;
    logic [1:0] c2 = '0;
    logic       rdy2, rv2, mis2;
    logic [3:0] alu_a2, alu_b2, alu_c2, rc2, re2;
    logic [1:0] alu_ctrl2;
    logic [1:0] pass2, fail2;
`ifdef ALU_CHECK_STICKY_EN
    logic        fseen2;
    logic [13:0] fvec2;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] a, b;
        logic [1:0] c;
        logic [3:0] rc, exp;
        logic       mis;
        int         due;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [3:0] alu_ref(logic [3:0] a, logic [3:0] b, logic [1:0] c);
        int r;
        case (c)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return 4'(r & 15);
    endfunction

    assign alu_c  = alu_ref(alu_a, alu_b, alu_ctrl) ^ {3'b000, fault};
    assign alu_c2 = alu_ref(alu_a2, alu_b2, alu_ctrl2);

    alu_vector_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_c(alu_c),
        .clear_counts(clear_counts), .res_valid(res_valid), .res_c(res_c),
        .res_expected(res_expected), .res_mismatch(res_mismatch),
        .pass_count(pass_count), .fail_count(fail_count)
`ifdef ALU_CHECK_STICKY_EN
        , .fail_seen(fail_seen), .fail_vec(fail_vec)
`endif
    );

    alu_vector_checker #(.WIDTH(4), .SETTLE_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
        .in_a(a2), .in_b(b2), .in_ctrl(c2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_ctrl(alu_ctrl2), .alu_c(alu_c2),
        .clear_counts(1'b0), .res_valid(rv2), .res_c(rc2),
        .res_expected(re2), .res_mismatch(mis2),
        .pass_count(pass2), .fail_count(fail2)
`ifdef ALU_CHECK_STICKY_EN
        , .fail_seen(fseen2), .fail_vec(fvec2)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: sampled 1 time unit after each rising edge
    int  m_pass = 0, m_fail = 0;
    bit  m_seen = 0;
    logic [13:0] m_vec = '0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                sbq.delete();
                m_pass = 0; m_fail = 0; m_seen = 0; m_vec = '0;
                chk("rst_res_valid", res_valid, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
                chk("rst_res", {res_c, res_expected, res_mismatch}, 0);
            end else begin
                if (clear_counts) begin
                    m_pass = 0; m_fail = 0; m_seen = 0; m_vec = '0;
                end
                if (res_valid) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_res_valid", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("latency", cyc, e.due);
                        chk("res_c", res_c, e.rc);
                        chk("res_expected", res_expected, e.exp);
                        chk("res_mismatch", res_mismatch, e.mis);
                        if (!clear_counts) begin
                            if (e.mis) begin
                                if (m_fail < CMAX) m_fail++;
                                if (!m_seen) begin
                                    m_seen = 1;
                                    m_vec  = {e.a, e.b, e.c, e.rc};
                                end
                            end else if (m_pass < CMAX) begin
                                m_pass++;
                            end
                        end
                    end
                end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
                    chk("missing_res_valid", 0, 1);
                    void'(sbq.pop_front());
                end
                chk("in_ready", in_ready, !(sbq.size() > 0 && cyc < sbq[0].due));
            end
            chk("pass_count", pass_count, m_pass);
            chk("fail_count", fail_count, m_fail);
`ifdef ALU_CHECK_STICKY_EN
            chk("fail_seen", fail_seen, m_seen);
            chk("fail_vec", fail_vec, m_vec);
`endif
        end
    end

    // Issue one vector; called and returning at a falling edge
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c,
                        input bit f, input bit keep, output int due);
        exp_t e;
        int t = 0;
        logic [3:0] r;
        in_a = a; in_b = b; in_ctrl = c; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            due = -1;
            return;
        end
        fault = f;
        r = alu_ref(a, b, c);
        e.a = a; e.b = b; e.c = c; e.exp = r; e.rc = r ^ {3'b000, f}; e.mis = f;
        e.due = cyc + 1 + S;
        sbq.push_back(e);
        due = e.due;
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sbq.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() > 0) chk("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int due;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send(4'd2, 4'd3, 2'd0, 0, 0, due);
        send(4'd2, 4'd3, 2'd1, 0, 0, due);
        send(4'd2, 4'd3, 2'd2, 0, 0, due);
        send(4'd2, 4'd3, 2'd3, 0, 0, due);
        send(4'd7, 4'd7, 2'd0, 0, 0, due);
        wait_idle();

        send(4'd3, 4'd2, 2'd1, 1, 0, due);
        wait_idle();
        fault = 1'b0;

        for (int i = 0; i < 4; i++)
            send(4'($urandom), 4'($urandom), 2'($urandom), 0, i < 3, due);
        wait_idle();

        send(4'd5, 4'd6, 2'd0, 0, 0, due);
        while (cyc < due - 1) @(negedge clk);
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        wait_idle();

        send(4'd1, 4'd1, 2'd0, 0, 0, due);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            send(4'($urandom), 4'($urandom), 2'($urandom), ($urandom % 4) == 0,
                 $urandom % 2, due);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle();

        v2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a2 = 4'($urandom); b2 = 4'($urandom); c2 = 2'($urandom);
            if (rdy2) begin
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        v2 = 1'b0;
        repeat (4) @(negedge clk);
        chk("sat_pass_count", pass2, 3);
        chk("sat_fail_count", fail2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_vector_checker.md
Name: alu_vector_checker

Overview:
- Synthesizable stimulus/response engine for the 4-bit two-operand ALU (operands A, B; opcode CTRL; result C).
- Accepts operand vectors over a valid/ready stream and drives them onto the ALU inputs.
- Waits a programmable settle time, which covers SDF-annotated gate delays, then samples C and compares it with an internal golden model.
- Reports each result and keeps pass/fail counters. It sits on the far side of the ALU from the vector source and closes the loop in gate-level simulation or on silicon.

Parameters:
- WIDTH, 4, operand/result width in bits.
- SETTLE_CYCLES, 4, full clock cycles operands are held stable before C is sampled; legal range 1..255.
- CNT_W, 16, width of the pass/fail counters.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand vector valid
- in_ready  output  1  checker can accept a vector
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_ctrl  input  2  opcode
- alu_a  output  WIDTH  registered drive to ALU A
- alu_b  output  WIDTH  registered drive to ALU B
- alu_ctrl  output  2  registered drive to ALU CTRL
- alu_c  input  WIDTH  ALU result
- clear_counts  input  1  synchronous counter clear
- res_valid  output  1  one-cycle result strobe
- res_c  output  WIDTH  sampled alu_c
- res_expected  output  WIDTH  golden result
- res_mismatch  output  1  res_c != res_expected
- pass_count  output  CNT_W  matching results
- fail_count  output  CNT_W  mismatching results

Behaviour:
- Reset values: all outputs 0 except in_ready=1; state IDLE.
- Golden model, mod 2^WIDTH, computed from the registered operands:
  - ctrl 0: A+B (wrap)
  - ctrl 1: A-B (two's-complement wrap)
  - ctrl 2: A&B
  - ctrl 3: A|B
- FSM states: IDLE, SETTLE, REPORT.
- in_ready is 1 in IDLE and REPORT, 0 in SETTLE.
- Accept: at edge T with in_valid & in_ready:
  - alu_a/alu_b/alu_ctrl load in_a/in_b/in_ctrl.
  - settle counter loads SETTLE_CYCLES.
  - state goes to SETTLE.
- SETTLE:
  - Each edge with counter > 1: decrement.
  - Edge with counter == 1, which is edge T+SETTLE_CYCLES: sample alu_c into res_c, load res_expected and res_mismatch, update one counter, go to REPORT.
- REPORT: lasts exactly one cycle, with res_valid=1.
  - If in_valid: accept the next vector (back-to-back) and go to SETTLE.
  - Otherwise go to IDLE.
- Throughput: one vector per SETTLE_CYCLES+1 cycles.
- Latency: accept at edge T; res_valid is high in the cycle following edge T+SETTLE_CYCLES.
- alu_* hold the last vector after the report; they do not return to 0.
- res_c/res_expected/res_mismatch hold until the next sample. They are only meaningful while res_valid=1.
- Counters saturate at 2^CNT_W-1; no wrap.
- clear_counts zeroes both counters on the next edge. If it coincides with the sample edge, clear wins and that result is not counted. res_valid/res_* still update.
- in_valid in SETTLE is ignored: not accepted, no overflow, the source must hold it.
- rst asserted mid-SETTLE or in REPORT: at that edge everything returns to reset values and no res_valid is produced for the aborted vector.
- The same edge cannot both accept and sample, except REPORT→SETTLE, where the sample already occurred on the previous edge.

Optional Feature:
- Macro ALU_CHECK_STICKY_EN.
- When defined, adds outputs:
  - fail_seen  1 bit
  - fail_vec  3*WIDTH+2 bits = {alu_a, alu_b, alu_ctrl, res_c}
- On the first mismatch after reset/clear, fail_seen sets and fail_vec captures that vector.
- Later mismatches do not overwrite fail_vec.
- rst or clear_counts zeroes both.
- When undefined, neither port nor logic exists; everything else is identical.

Test Plan:
- Reset, then idle 5 cycles → in_ready=1, res_valid never 1, alu_*=0, counters 0.
- Correct ALU model:
  - Send A=2,B=3,CTRL=0 → res_valid in the cycle after edge T+4; res_c=5, res_expected=5, res_mismatch=0, pass_count=1.
  - Then send CTRL=1,2,3 → expected 15, 2, 3.
  - Then send A=7,B=7,CTRL=0 → expected 14; all pass.
- Faulty ALU model returning C^1 → send A=3,B=2,CTRL=1 → res_c=0, res_expected=1, mismatch=1, fail_count=1.
  - With ALU_CHECK_STICKY_EN: fail_seen=1, fail_vec={3,2,1,0}.
- Hold in_valid high with 4 vectors → accepts only in IDLE/REPORT; res_valid every 5 cycles; in_ready=0 during SETTLE.
- Assert clear_counts on the sample edge → counters 0 afterwards, res_valid still pulses.
- Assert rst at edge T+2 → no res_valid, all reset values. CNT_W=2 with 5 passes → pass_count saturates at 3.
